// File: rtl/interrupt_controller_if.sv
// Core-side bundle for the interrupt controller: requests, config strobes and IP/store
// observation towards the controller; IP/EIP write controls and status back to the core.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic               mask_wr;
  logic [NUM_IRQ-1:0] mask_din;
  logic               gie_set;
  logic               gie_clr;
  logic [15:0]        k_val;
  logic [15:0]        ip_val;
  logic               mem_wr;
  logic [15:0]        mem_wr_addr;
  logic               instr_boundary;
  logic               iret;
  logic [15:0]        eip_val;

  logic               stall;
  logic               wr_block;
  logic               eip_write;
  logic               ip_load;
  logic [15:0]        ip_load_val;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [2:0]         cause;
  logic               in_service;
  logic               halted;

  modport master (
    output irq, mask_wr, mask_din, gie_set, gie_clr, k_val, ip_val,
           mem_wr, mem_wr_addr, instr_boundary, iret, eip_val,
    input  stall, wr_block, eip_write, ip_load, ip_load_val, irq_ack,
           cause, in_service, halted
  );

  modport slave (
    input  irq, mask_wr, mask_din, gie_set, gie_clr, k_val, ip_val,
           mem_wr, mem_wr_addr, instr_boundary, iret, eip_val,
    output stall, wr_block, eip_write, ip_load, ip_load_val, irq_ack,
           cause, in_service, halted
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt entry/return sequencer with K-boundary store guard; entry takes 2 cycles
// (SAVE, VECTOR) after the decision edge, and the core is stalled while IP/EIP are owned.
module interrupt_controller #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter int          VEC_STRIDE = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  interrupt_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_VECTOR, S_SERVICE, S_RETURN, S_HALT
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] eligible;
  logic               gie;
  logic               fault_pending;
  logic               violation;
  logic [17:0]        k4;
  logic [2:0]         cause;
  logic [2:0]         win_cause;
  logic [2:0]         entry_cause;
  logic [15:0]        vec_addr;

  logic               stall_c;
  logic               eip_write_c;
  logic               ip_load_c;
  logic [15:0]        ip_load_val_c;
  logic [NUM_IRQ-1:0] irq_ack_c;
  logic               in_service_c;
  logic               halted_c;

  // Compare at 18 bits so a boundary near the top of memory cannot wrap to a small value.
  assign k4        = {bus.k_val, 2'b00};
  assign violation = bus.mem_wr
                   && ({2'b00, bus.ip_val} < k4)
                   && ({2'b00, bus.mem_wr_addr} < k4);
  assign eligible  = bus.irq & mask & {NUM_IRQ{gie}};
  assign vec_addr  = VEC_BASE + 16'(cause) * 16'(VEC_STRIDE);

  always_comb begin
    win_cause = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_cause = 3'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    entry_cause = 3'd0;
    case (state)
      S_IDLE: begin
        if (fault_pending || violation) begin
          state_nx    = S_SAVE;
          entry_cause = 3'd0;
        end else if (bus.instr_boundary && (|eligible)) begin
          state_nx    = S_SAVE;
          entry_cause = win_cause;
        end
      end
      S_SAVE:    state_nx = S_VECTOR;
      S_VECTOR:  state_nx = S_SERVICE;
      S_SERVICE: begin
        if (fault_pending || violation) state_nx = S_HALT;
        else if (bus.iret)              state_nx = S_RETURN;
      end
      S_RETURN:  state_nx = S_IDLE;
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask          <= '0;
      gie           <= 1'b0;
      fault_pending <= 1'b0;
      cause         <= 3'd0;
    end else begin
      if (bus.mask_wr) mask <= bus.mask_din;

      // Entry and return own gie; EI is only honoured outside a handler.
      if (state == S_SAVE)                         gie <= 1'b0;
      else if (state == S_RETURN)                  gie <= 1'b1;
      else if (bus.gie_clr)                        gie <= 1'b0;
      else if (bus.gie_set && (state == S_IDLE))   gie <= 1'b1;

      fault_pending <= violation
                    || (fault_pending && !((state == S_SAVE) && (cause == 3'd0)));

      if ((state == S_IDLE) && (state_nx == S_SAVE)) cause <= entry_cause;
    end
  end

  always_comb begin
    stall_c       = 1'b0;
    eip_write_c   = 1'b0;
    ip_load_c     = 1'b0;
    ip_load_val_c = 16'h0000;
    irq_ack_c     = '0;
    in_service_c  = 1'b0;
    halted_c      = 1'b0;
    case (state)
      S_SAVE: begin
        stall_c     = 1'b1;
        eip_write_c = 1'b1;
        for (int i = 0; i < NUM_IRQ; i++) begin
          irq_ack_c[i] = (cause == 3'(i + 1));
        end
      end
      S_VECTOR: begin
        stall_c       = 1'b1;
        ip_load_c     = 1'b1;
        ip_load_val_c = vec_addr;
      end
      S_SERVICE: in_service_c = 1'b1;
      S_RETURN: begin
        stall_c       = 1'b1;
        ip_load_c     = 1'b1;
        ip_load_val_c = bus.eip_val;
      end
      S_HALT: begin
        stall_c  = 1'b1;
        halted_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.stall       = stall_c;
  assign bus.wr_block    = violation;
  assign bus.eip_write   = eip_write_c;
  assign bus.ip_load     = ip_load_c;
  assign bus.ip_load_val = ip_load_val_c;
  assign bus.irq_ack     = irq_ack_c;
  assign bus.cause       = cause;
  assign bus.in_service  = in_service_c;
  assign bus.halted      = halted_c;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed walk through entry/return/fault/halt scenarios, then randomized traffic, all
// compared each cycle against a timeline model of the controller's visible behaviour.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_IRQ(4)) bus ();

  interrupt_controller #(
    .NUM_IRQ    (4),
    .VEC_BASE   (16'h0010),
    .VEC_STRIDE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: a queue of forced cycles (entry or return) plus a coarse mode.
  typedef struct {
    bit          stall;
    bit          ew;
    bit          il;
    bit          is_ret;
    logic [15:0] val;
    logic [3:0]  ack;
    int          gie_op;   // 0 none, 1 clear, 2 set
    bit          clr_fp;
  } ev_t;

  ev_t        q[$];
  logic [3:0] m_mask;
  bit         m_gie;
  bit         m_fp;
  int         m_cause;
  int         m_mode;      // 0 free, 1 handler, 2 halted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mask = 4'h0; m_gie = 0; m_fp = 0; m_cause = 0; m_mode = 0;
    q.delete();
  endfunction

  function automatic bit viol();
    int k4;
    k4 = int'(bus.k_val) * 4;
    return bus.mem_wr && (int'(bus.ip_val) < k4) && (int'(bus.mem_wr_addr) < k4);
  endfunction

  function automatic logic [28:0] dut_vec();
    return {bus.stall, bus.wr_block, bus.eip_write, bus.ip_load, bus.ip_load_val,
            bus.irq_ack, bus.cause, bus.in_service, bus.halted};
  endfunction

  function automatic logic [28:0] model_out();
    bit st, ew, il, ins, hl;
    logic [15:0] v;
    logic [3:0]  ack;
    st = 0; ew = 0; il = 0; ins = 0; hl = 0; v = 16'h0; ack = 4'h0;
    if (!rst_n) return {1'b0, viol(), 27'h0};
    if (q.size() > 0) begin
      st = q[0].stall; ew = q[0].ew; il = q[0].il; ack = q[0].ack;
      v  = q[0].is_ret ? bus.eip_val : q[0].val;
    end else if (m_mode == 2) begin
      st = 1; hl = 1;
    end else if (m_mode == 1) begin
      ins = 1;
    end
    return {st, viol(), ew, il, v, ack, 3'(m_cause), ins, hl};
  endfunction

  function automatic void enter(int c);
    ev_t e;
    m_cause = c;
    e.stall = 1; e.ew = 1; e.il = 0; e.is_ret = 0; e.val = 16'h0;
    e.ack = (c == 0) ? 4'h0 : 4'(1 << (c - 1)); e.gie_op = 1; e.clr_fp = (c == 0);
    q.push_back(e);
    e.ew = 0; e.il = 1; e.val = 16'(16 + 4 * c); e.ack = 4'h0; e.gie_op = 0; e.clr_fp = 0;
    q.push_back(e);
    m_mode = 1;
  endfunction

  function automatic void model_update();
    bit v, old_fp;
    logic [3:0] elig;
    ev_t e, r;
    int c;
    if (!rst_n) begin model_reset(); return; end
    v = viol();
    old_fp = m_fp;
    elig = bus.irq & m_mask & (m_gie ? 4'hF : 4'h0);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.clr_fp) m_fp = 0;
      if (e.gie_op == 1)      m_gie = 0;
      else if (e.gie_op == 2) m_gie = 1;
      else if (bus.gie_clr)   m_gie = 0;
    end else begin
      if (bus.gie_clr) m_gie = 0;
      else if (bus.gie_set && m_mode == 0) m_gie = 1;
      if (m_mode == 0) begin
        if (old_fp || v) enter(0);
        else if (bus.instr_boundary && elig != 4'h0) begin
          c = 0;
          for (int i = 3; i >= 0; i--) if (elig[i]) c = i + 1;
          enter(c);
        end
      end else if (m_mode == 1) begin
        if (old_fp || v) m_mode = 2;
        else if (bus.iret) begin
          r.stall = 1; r.ew = 0; r.il = 1; r.is_ret = 1; r.val = 16'h0;
          r.ack = 4'h0; r.gie_op = 2; r.clr_fp = 0;
          q.push_back(r);
          m_mode = 0;
        end
      end
    end
    if (v) m_fp = 1;
    if (bus.mask_wr) m_mask = bus.mask_din;
  endfunction

  task automatic step();
    @(negedge clk);
    chk($sformatf("cycle%0d", cyc), 32'(dut_vec()), 32'(model_out()));
    model_update();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_handler();   // from SAVE through RETURN back to IDLE
    step(); step();
    bus.iret = 1; step();
    bus.iret = 0; step();
  endtask

  initial begin
    bus.irq = 4'h0; bus.mask_wr = 0; bus.mask_din = 4'h0; bus.gie_set = 0; bus.gie_clr = 0;
    bus.k_val = 16'h0; bus.ip_val = 16'h0; bus.mem_wr = 0; bus.mem_wr_addr = 16'h0;
    bus.instr_boundary = 0; bus.iret = 0; bus.eip_val = 16'h0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #2;
    chk("reset_outs", 32'(dut_vec()), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Masked irq entry: irq[1] wins, vector 0x18
    bus.mask_wr = 1; bus.mask_din = 4'b0010; bus.gie_set = 1; step();
    bus.mask_wr = 0; bus.gie_set = 0;
    bus.irq = 4'b0110; bus.instr_boundary = 1; bus.ip_val = 16'h0040; step();
    chk("save_eip_write", 32'(bus.eip_write), 32'd1);
    chk("save_ack", 32'(bus.irq_ack), 32'h2);
    chk("save_cause", 32'(bus.cause), 32'd2);
    bus.irq = 4'h0; bus.instr_boundary = 0; step();
    chk("vector_val", 32'(bus.ip_load_val), 32'h0018);
    step();
    chk("in_service", 32'(bus.in_service), 32'd1);

    // Return, then a pending irq waits for an instruction boundary
    bus.iret = 1; bus.eip_val = 16'h0040; step();
    chk("ret_load", 32'(bus.ip_load), 32'd1);
    chk("ret_val", 32'(bus.ip_load_val), 32'h0040);
    bus.iret = 0; bus.irq = 4'b0010; step(); step();
    chk("no_take_without_ib", 32'({bus.stall, bus.in_service}), 32'd0);
    bus.instr_boundary = 1; step();
    chk("take_at_ib", 32'({bus.eip_write, bus.cause}), 32'h0A);
    bus.instr_boundary = 0; bus.irq = 4'h0; finish_handler();

    // K-rule violation faults immediately
    bus.k_val = 16'h0008; bus.ip_val = 16'h0010; bus.mem_wr_addr = 16'h0005; bus.mem_wr = 1;
    #1 chk("wr_block_same_cycle", 32'(bus.wr_block), 32'd1);
    step();
    bus.mem_wr = 0;
    chk("fault_cause", 32'({bus.eip_write, bus.cause, bus.irq_ack}), 32'h80);
    step();
    chk("fault_vector", 32'(bus.ip_load_val), 32'h0010);
    step(); bus.iret = 1; step(); bus.iret = 0; step();
    bus.ip_val = 16'h0020; bus.mem_wr = 1;
    #1 chk("ip_at_k4_no_block", 32'(bus.wr_block), 32'd0);
    step();
    chk("ip_at_k4_no_entry", 32'(bus.stall), 32'd0);
    bus.k_val = 16'hFFFF; bus.ip_val = 16'hFFFF; bus.mem_wr_addr = 16'hFFFF;
    #1 chk("k4_no_wrap", 32'(bus.wr_block), 32'd1);
    bus.mem_wr = 0; bus.k_val = 16'h0008; bus.ip_val = 16'h0010; bus.mem_wr_addr = 16'h0005;

    // Fault beats irq[0]; irq[0] served after iret
    bus.mask_wr = 1; bus.mask_din = 4'b0011; step();
    bus.mask_wr = 0; bus.irq = 4'b0001; bus.instr_boundary = 1; bus.mem_wr = 1; step();
    bus.mem_wr = 0;
    chk("fault_wins_cause", 32'(bus.cause), 32'd0);
    chk("fault_wins_ack", 32'(bus.irq_ack), 32'd0);
    step(); step(); step();
    chk("no_nesting", 32'({bus.in_service, bus.irq_ack}), 32'h10);
    bus.iret = 1; step(); bus.iret = 0; step(); step();
    chk("irq0_after_iret", 32'({bus.cause, bus.irq_ack}), 32'h11);
    bus.irq = 4'h0; bus.instr_boundary = 0; finish_handler();

    // gie=0 / mask=0 block entry; reset during VECTOR aborts
    bus.gie_clr = 1; step(); bus.gie_clr = 0;
    bus.irq = 4'hF; bus.instr_boundary = 1; step(); step();
    chk("gie0_no_entry", 32'(bus.stall), 32'd0);
    bus.gie_set = 1; bus.mask_wr = 1; bus.mask_din = 4'h0; step();
    bus.gie_set = 0; bus.mask_wr = 0; step();
    chk("mask0_no_entry", 32'(bus.stall), 32'd0);
    bus.mask_wr = 1; bus.mask_din = 4'b1000; step();
    bus.mask_wr = 0; step();
    chk("irq3_cause", 32'({bus.cause, bus.irq_ack}), 32'h48);
    step();
    chk("irq3_vector", 32'(bus.ip_load_val), 32'h0020);
    rst_n = 0;
    #1;
    chk("rst_vec_ip_load", 32'(bus.ip_load), 32'd0);
    chk("rst_vec_stall", 32'(bus.stall), 32'd0);
    chk("rst_vec_cause", 32'(bus.cause), 32'd0);
    step(); rst_n = 1;
    bus.irq = 4'h0; bus.instr_boundary = 0;

    // Violation inside a handler halts until reset
    bus.mem_wr = 1; step(); bus.mem_wr = 0; step(); step();
    bus.mem_wr = 1; step(); bus.mem_wr = 0;
    for (int i = 0; i < 20; i++) step();
    chk("halt_held", 32'({bus.halted, bus.stall}), 32'd3);
    rst_n = 0;
    #1 chk("halt_cleared", 32'({bus.halted, bus.stall}), 32'd0);
    step(); rst_n = 1;

    // Randomized traffic
    begin
      int halt_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
        if ((m_mode == 2 && q.size() == 0 && halt_cnt > 4) || $urandom_range(0, 499) == 0) begin
          bus.mem_wr = 0; rst_n = 0; step(); rst_n = 1; halt_cnt = 0;
        end else begin
          bus.irq            = 4'($urandom_range(0, 15));
          bus.mask_wr        = ($urandom_range(0, 15) == 0);
          bus.mask_din       = 4'($urandom_range(0, 15));
          bus.gie_set        = ($urandom_range(0, 7) == 0);
          bus.gie_clr        = ($urandom_range(0, 31) == 0);
          bus.instr_boundary = ($urandom_range(0, 1) == 1);
          bus.iret           = ($urandom_range(0, 5) == 0);
          bus.mem_wr         = ($urandom_range(0, 7) == 0);
          bus.k_val          = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
          bus.ip_val         = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 80));
          bus.mem_wr_addr    = 16'($urandom_range(0, 80));
          bus.eip_val        = 16'($urandom);
          step();
          if (m_mode == 2) halt_cnt++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
